// File: rtl/lookup_scan_ctrl.sv
// Lookup sequencing controller: holds a DEPTH-entry element table and scans it one entry
// per cycle for the best match. Optional macro LOOKUP_EARLY_EXIT_EN stops on the first match.
module lookup_scan_ctrl #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_index,
    input  logic [7:0]        wr_value,
    input  logic [7:0]        wr_rank,
    input  logic [7:0]        wr_metadata,
    input  logic              wr_isMetadata,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [7:0]        req_index,
    input  logic [7:0]        req_low,
    input  logic [7:0]        req_high,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_found,
    output logic [7:0]        resp_value,
    output logic [7:0]        resp_context,
    output logic [ADDR_W-1:0] resp_addr
);

    // state | meaning
    // IDLE  | waiting for a request; table writable
    // SCAN  | evaluating entry scan_addr each cycle; table write-protected
    // DONE  | response presented from best-match register; table writable
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] scan_addr_q, scan_addr_d;
    logic [7:0]        key_index_q, key_index_d;
    logic [7:0]        key_low_q, key_low_d;
    logic [7:0]        key_high_q, key_high_d;
    logic              best_found_q, best_found_d;
    logic [ADDR_W-1:0] best_addr_q, best_addr_d;
    logic [7:0]        best_value_q, best_value_d;
    logic [7:0]        best_rank_q, best_rank_d;
    logic              resp_valid_q, resp_valid_d;

    logic [7:0] tbl_index_q [DEPTH];
    logic [7:0] tbl_index_d [DEPTH];
    logic [7:0] tbl_value_q [DEPTH];
    logic [7:0] tbl_value_d [DEPTH];
    logic [7:0] tbl_rank_q  [DEPTH];
    logic [7:0] tbl_rank_d  [DEPTH];
    logic [7:0] tbl_meta_q  [DEPTH];
    logic [7:0] tbl_meta_d  [DEPTH];
    logic       tbl_ismeta_q [DEPTH];
    logic       tbl_ismeta_d [DEPTH];

    logic       entry_match;
    logic       wr_accept;

    assign wr_ready     = (state_q != ST_SCAN);
    assign req_ready    = (state_q == ST_IDLE);
    assign resp_valid   = resp_valid_q;
    assign resp_found   = best_found_q;
    assign resp_value   = best_value_q;
    assign resp_context = best_rank_q;
    assign resp_addr    = best_addr_q;

    assign wr_accept = wr_en & wr_ready;

    // An inverted bound (low > high) can never satisfy both compares, so no special case.
    assign entry_match = tbl_ismeta_q[scan_addr_q]
                       & (tbl_index_q[scan_addr_q] == key_index_q)
                       & (tbl_meta_q[scan_addr_q] >= key_low_q)
                       & (tbl_meta_q[scan_addr_q] <= key_high_q);

    always_comb begin
        state_d      = state_q;
        scan_addr_d  = scan_addr_q;
        key_index_d  = key_index_q;
        key_low_d    = key_low_q;
        key_high_d   = key_high_q;
        best_found_d = best_found_q;
        best_addr_d  = best_addr_q;
        best_value_d = best_value_q;
        best_rank_d  = best_rank_q;
        resp_valid_d = resp_valid_q;
        tbl_index_d  = tbl_index_q;
        tbl_value_d  = tbl_value_q;
        tbl_rank_d   = tbl_rank_q;
        tbl_meta_d   = tbl_meta_q;
        tbl_ismeta_d = tbl_ismeta_q;

        if (wr_accept) begin
            tbl_index_d[wr_addr]  = wr_index;
            tbl_value_d[wr_addr]  = wr_value;
            tbl_rank_d[wr_addr]   = wr_rank;
            tbl_meta_d[wr_addr]   = wr_metadata;
            tbl_ismeta_d[wr_addr] = wr_isMetadata;
        end

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    key_index_d  = req_index;
                    key_low_d    = req_low;
                    key_high_d   = req_high;
                    best_found_d = 1'b0;
                    best_addr_d  = '0;
                    best_value_d = 8'd0;
                    best_rank_d  = 8'd0;
                    scan_addr_d  = '0;
                    state_d      = ST_SCAN;
                end
            end
            ST_SCAN: begin
`ifdef LOOKUP_EARLY_EXIT_EN
                if (entry_match) begin
                    best_found_d = 1'b1;
                    best_addr_d  = scan_addr_q;
                    best_value_d = tbl_value_q[scan_addr_q];
                    best_rank_d  = tbl_rank_q[scan_addr_q];
                end
                if (entry_match || (scan_addr_q == LAST_ADDR)) begin
                    state_d      = ST_DONE;
                    resp_valid_d = 1'b1;
                end else begin
                    scan_addr_d = scan_addr_q + 1'b1;
                end
`else
                // Strict greater-than keeps the lower address on a rank tie.
                if (entry_match && (!best_found_q || (tbl_rank_q[scan_addr_q] > best_rank_q))) begin
                    best_found_d = 1'b1;
                    best_addr_d  = scan_addr_q;
                    best_value_d = tbl_value_q[scan_addr_q];
                    best_rank_d  = tbl_rank_q[scan_addr_q];
                end
                if (scan_addr_q == LAST_ADDR) begin
                    state_d      = ST_DONE;
                    resp_valid_d = 1'b1;
                end else begin
                    scan_addr_d = scan_addr_q + 1'b1;
                end
`endif
            end
            ST_DONE: begin
                if (resp_ready) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                resp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            scan_addr_q  <= '0;
            key_index_q  <= 8'd0;
            key_low_q    <= 8'd0;
            key_high_q   <= 8'd0;
            best_found_q <= 1'b0;
            best_addr_q  <= '0;
            best_value_q <= 8'd0;
            best_rank_q  <= 8'd0;
            resp_valid_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                tbl_index_q[i]  <= 8'd0;
                tbl_value_q[i]  <= 8'd0;
                tbl_rank_q[i]   <= 8'd0;
                tbl_meta_q[i]   <= 8'd0;
                tbl_ismeta_q[i] <= 1'b0;
            end
        end else begin
            state_q      <= state_d;
            scan_addr_q  <= scan_addr_d;
            key_index_q  <= key_index_d;
            key_low_q    <= key_low_d;
            key_high_q   <= key_high_d;
            best_found_q <= best_found_d;
            best_addr_q  <= best_addr_d;
            best_value_q <= best_value_d;
            best_rank_q  <= best_rank_d;
            resp_valid_q <= resp_valid_d;
            tbl_index_q  <= tbl_index_d;
            tbl_value_q  <= tbl_value_d;
            tbl_rank_q   <= tbl_rank_d;
            tbl_meta_q   <= tbl_meta_d;
            tbl_ismeta_q <= tbl_ismeta_d;
        end
    end

endmodule

// File: tb/tb_lookup_scan_ctrl.sv
// Directed scoreboard bench for lookup_scan_ctrl; expectations come from a local table model.
module tb_lookup_scan_ctrl;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_index, wr_value, wr_rank, wr_metadata;
    logic              wr_isMetadata;
    logic              req_valid;
    logic              req_ready;
    logic [7:0]        req_index, req_low, req_high;
    logic              resp_valid;
    logic              resp_ready;
    logic              resp_found;
    logic [7:0]        resp_value, resp_context;
    logic [ADDR_W-1:0] resp_addr;

    lookup_scan_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_index(wr_index), .wr_value(wr_value), .wr_rank(wr_rank),
        .wr_metadata(wr_metadata), .wr_isMetadata(wr_isMetadata),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_index(req_index), .req_low(req_low), .req_high(req_high),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_found(resp_found), .resp_value(resp_value),
        .resp_context(resp_context), .resp_addr(resp_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       found;
        logic [7:0] value;
        logic [7:0] ctx;
        logic [3:0] addr;
        int         lat;
    } exp_t;

    exp_t sb[$];
    exp_t cur;

    logic [7:0] m_index [DEPTH];
    logic [7:0] m_value [DEPTH];
    logic [7:0] m_rank  [DEPTH];
    logic [7:0] m_meta  [DEPTH];
    logic       m_ism   [DEPTH];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int acc_cyc  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_index[i] = 8'd0; m_value[i] = 8'd0; m_rank[i] = 8'd0;
            m_meta[i] = 8'd0;  m_ism[i] = 1'b0;
        end
    endtask

    function automatic exp_t model_lookup(input logic [7:0] idx, input logic [7:0] lo,
                                          input logic [7:0] hi);
        exp_t e;
        e.found = 1'b0; e.value = 8'd0; e.ctx = 8'd0; e.addr = 4'd0; e.lat = DEPTH + 1;
        for (int a = 0; a < DEPTH; a++) begin
            if (m_ism[a] && m_index[a] == idx && m_meta[a] >= lo && m_meta[a] <= hi) begin
`ifdef LOOKUP_EARLY_EXIT_EN
                if (!e.found) begin
                    e.found = 1'b1; e.value = m_value[a]; e.ctx = m_rank[a];
                    e.addr = 4'(a); e.lat = a + 2;
                end
`else
                if (!e.found || m_rank[a] > e.ctx) begin
                    e.found = 1'b1; e.value = m_value[a]; e.ctx = m_rank[a]; e.addr = 4'(a);
                end
`endif
            end
        end
        return e;
    endfunction

    // Drives a one-cycle write; exp_store says whether the DUT should be accepting writes.
    task automatic write_entry(input int a, input logic [7:0] idx, input logic [7:0] val,
                               input logic [7:0] rank, input logic [7:0] meta,
                               input logic ism, input logic exp_store);
        check("wr_ready_at_write", {31'd0, wr_ready}, {31'd0, exp_store});
        wr_addr = 4'(a); wr_index = idx; wr_value = val; wr_rank = rank;
        wr_metadata = meta; wr_isMetadata = ism; wr_en = 1'b1;
        if (exp_store) begin
            m_index[a] = idx; m_value[a] = val; m_rank[a] = rank;
            m_meta[a] = meta; m_ism[a] = ism;
        end
        tick();
        wr_en = 1'b0;
    endtask

    task automatic start_lookup(input logic [7:0] idx, input logic [7:0] lo, input logic [7:0] hi);
        check("req_ready_before_req", {31'd0, req_ready}, 32'd1);
        sb.push_back(model_lookup(idx, lo, hi));
        req_index = idx; req_low = lo; req_high = hi; req_valid = 1'b1;
        tick();
        acc_cyc = cyc;
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(input string tag);
        int lat;
        while (!resp_valid && (cyc - acc_cyc) < 200) tick();
        lat = cyc - acc_cyc + 1;
        check({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd1);
        if (sb.size() == 0) begin
            check({tag, "_sb_nonempty"}, 32'd0, 32'd1);
        end else begin
            cur = sb.pop_front();
            check({tag, "_found"},   {31'd0, resp_found},   {31'd0, cur.found});
            check({tag, "_value"},   {24'd0, resp_value},   {24'd0, cur.value});
            check({tag, "_context"}, {24'd0, resp_context}, {24'd0, cur.ctx});
            check({tag, "_addr"},    {28'd0, resp_addr},    {28'd0, cur.addr});
            check({tag, "_latency"}, 32'(lat),             32'(cur.lat));
        end
    endtask

    task automatic finish_resp(input string tag);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check({tag, "_valid_drop"}, {31'd0, resp_valid}, 32'd0);
        check({tag, "_req_ready"},  {31'd0, req_ready},  32'd1);
    endtask

    task automatic lookup(input string tag, input logic [7:0] idx, input logic [7:0] lo,
                          input logic [7:0] hi);
        start_lookup(idx, lo, hi);
        wait_resp(tag);
        finish_resp(tag);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_index = 8'd0; wr_value = 8'd0;
        wr_rank = 8'd0; wr_metadata = 8'd0; wr_isMetadata = 1'b0;
        req_valid = 1'b0; req_index = 8'd0; req_low = 8'd0; req_high = 8'd0;
        resp_ready = 1'b0;
        model_clear();
        tick(); tick();
        rst = 1'b0;

        // 1: reset state and lookup on an empty table
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_req_ready",  {31'd0, req_ready},  32'd1);
        check("rst_wr_ready",   {31'd0, wr_ready},   32'd1);
        check("rst_found",      {31'd0, resp_found}, 32'd0);
        check("rst_value",      {24'd0, resp_value}, 32'd0);
        check("rst_context",    {24'd0, resp_context}, 32'd0);
        check("rst_addr",       {28'd0, resp_addr},  32'd0);
        lookup("empty", 8'h00, 8'h00, 8'hFF);

        // 2: single match
        write_entry(5, 8'h12, 8'hAB, 8'd3, 8'h40, 1'b1, 1'b1);
        lookup("single", 8'h12, 8'h40, 8'h40);

        // 3: rank arbitration with a tie between addresses 2 and 9
        write_entry(2,  8'h07, 8'h11, 8'd9, 8'h10, 1'b1, 1'b1);
        write_entry(9,  8'h07, 8'h22, 8'd9, 8'h10, 1'b1, 1'b1);
        write_entry(12, 8'h07, 8'h33, 8'd4, 8'h10, 1'b1, 1'b1);
        lookup("rank", 8'h07, 8'h00, 8'hFF);

        // last-address boundary
        write_entry(15, 8'h5A, 8'h77, 8'd1, 8'h00, 1'b1, 1'b1);
        lookup("last_addr", 8'h5A, 8'h00, 8'h00);

        // 4: filter misses
        write_entry(2,  8'h07, 8'h44, 8'd5, 8'h50, 1'b0, 1'b1);
        write_entry(9,  8'h07, 8'h55, 8'd5, 8'h60, 1'b1, 1'b1);
        write_entry(12, 8'h07, 8'h66, 8'd5, 8'h10, 1'b0, 1'b1);
        lookup("range_miss", 8'h07, 8'h51, 8'h5F);
        lookup("inverted",   8'h07, 8'h70, 8'h10);
        lookup("range_hit",  8'h07, 8'h60, 8'h60);

        // 5: writes during SCAN are dropped, during DONE stored; stall holds response
        start_lookup(8'h12, 8'h40, 8'h40);
        tick(); tick();
        write_entry(3, 8'h12, 8'hEE, 8'hFF, 8'h40, 1'b1, 1'b0);
        wait_resp("stall");
        write_entry(4, 8'h12, 8'hDD, 8'hFE, 8'h40, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("stall_valid",   {31'd0, resp_valid},   32'd1);
            check("stall_value",   {24'd0, resp_value},   {24'd0, cur.value});
            check("stall_context", {24'd0, resp_context}, {24'd0, cur.ctx});
            check("stall_addr",    {28'd0, resp_addr},    {28'd0, cur.addr});
            check("stall_req_rdy", {31'd0, req_ready},    32'd0);
            tick();
        end
        finish_resp("stall");
        lookup("after_done_wr", 8'h12, 8'h40, 8'h40);

        // 6: reset at scan cycle 8 aborts the lookup and clears the table
        start_lookup(8'h12, 8'h00, 8'hFF);
        while ((cyc - acc_cyc) < 7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        void'(sb.pop_front());
        model_clear();
        check("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("midrst_req_ready",  {31'd0, req_ready},  32'd1);
        check("midrst_wr_ready",   {31'd0, wr_ready},   32'd1);
        for (int i = 0; i < DEPTH + 4; i++) begin
            if (resp_valid) check("midrst_no_resp", {31'd0, resp_valid}, 32'd0);
            tick();
        end
        lookup("post_rst", 8'h12, 8'h00, 8'hFF);
        lookup("post_rst7", 8'h07, 8'h00, 8'hFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
